// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, icache frame and FSM state.
// Widths derived for the default 16-frame icache.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  // Tag field sized for the smallest legal cache (2 sets);
  // larger caches zero-extend their tag into it.
  localparam int ICACHE_TAG_MAX_W = 29;

  typedef struct packed {
    logic                        valid;
    logic [ICACHE_TAG_MAX_W-1:0] tag;
    word_t                       data;
  } icache_frame_t;

  typedef enum logic {
    IDLE,
    FETCH
  } icache_state_t;

endpackage

// File: rtl/icache_fsm.sv
// icache miss FSM: state, miss_addr latch, iREN/iaddr, fill enable.
// Ports: CLK, nRST, miss, req_waddr, iwait -> idle, iREN, iaddr, fill_en, miss_addr.
module icache_fsm
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        miss,
  input  logic [29:0] req_waddr,
  input  logic        iwait,
  output logic        idle,
  output logic        iREN,
  output word_t       iaddr,
  output logic        fill_en,
  output word_t       miss_addr
);

  icache_state_t state, next_state;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && miss)
        miss_addr <= {req_waddr, 2'b00};
    end
  end

  always_comb begin
    next_state = state;
    idle       = 1'b0;
    iREN       = 1'b0;
    iaddr      = '0;
    fill_en    = 1'b0;
    unique case (state)
      IDLE: begin
        idle = 1'b1;
        if (miss)
          next_state = FETCH;
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = miss_addr;
        if (!iwait) begin
          fill_en    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-block instruction cache with hit/miss counters.
// Ports: CLK, nRST, imemREN/imemaddr -> ihit/imemload; iREN/iaddr/iwait/iload; counters.
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  icache_frame_t frames [SETS];

  logic             idle;
  logic             hit;
  logic             miss;
  logic             fill_en;
  word_t            miss_addr;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             unused_bits;

  assign req_idx  = imemaddr[IDX_W+1:2];
  assign req_tag  = imemaddr[31:IDX_W+2];
  assign fill_idx = miss_addr[IDX_W+1:2];
  assign fill_tag = miss_addr[31:IDX_W+2];

  // Byte offsets are irrelevant to a word cache.
  assign unused_bits = ^{imemaddr[1:0], miss_addr[1:0]};

  assign hit = imemREN && idle
            && frames[req_idx].valid
            && frames[req_idx].tag
               == ICACHE_TAG_MAX_W'(req_tag);
  assign miss = imemREN && idle && !hit;

  assign ihit     = hit;
  assign imemload = hit ? frames[req_idx].data : '0;

  icache_fsm u_fsm (
    .CLK       (CLK),
    .nRST      (nRST),
    .miss      (miss),
    .req_waddr (imemaddr[31:2]),
    .iwait     (iwait),
    .idle      (idle),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .fill_en   (fill_en),
    .miss_addr (miss_addr)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SETS; i++)
        frames[i] <= '0;
    end else if (fill_en) begin
      frames[fill_idx] <= '{
        valid: 1'b1,
        tag:   ICACHE_TAG_MAX_W'(fill_tag),
        data:  iload
      };
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit)
        hit_count <= hit_count + 32'd1;
      if (miss)
        miss_count <= miss_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache against a line-level cache model.
// Memory returns a fixed function of the requested address.
module tb_icache;

  localparam int SETS = 16;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int total;
  int bad;

  // Model: per-line valid, word address held, data held.
  logic        m_valid [SETS];
  logic [31:0] m_addr  [SETS];
  logic [31:0] m_data  [SETS];
  int unsigned exp_hits;
  int unsigned exp_misses;

  icache #(.SETS(SETS)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h2001_0005;
    if (a == 32'h0000_0044) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) + 32'h0000_1357;
  endfunction

  assign iload = (iREN && !iwait) ? mem_fn(iaddr) : 32'h0;

  task automatic model_clear();
    for (int i = 0; i < SETS; i++) begin
      m_valid[i] = 1'b0;
      m_addr[i]  = '0;
      m_data[i]  = '0;
    end
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic check_counters(input string name);
    @(posedge CLK); #1;
    imemREN  = 1'b0;
    imemaddr = $urandom;
    @(negedge CLK);
    total++;
    if (hit_count !== exp_hits || miss_count !== exp_misses
        || ihit !== 1'b0 || iREN !== 1'b0) begin
      bad++;
      $display("FAIL %s: hits=%0d misses=%0d ihit=%b iREN=%b, want hits=%0d misses=%0d ihit=0 iREN=0",
               name, hit_count, miss_count, ihit, iREN,
               exp_hits, exp_misses);
    end
  endtask

  // One fetch from request to delivered instruction.
  task automatic do_fetch(input logic [31:0] a, input int waits,
                          input bit perturb);
    logic [31:0] wa;
    int          idx;
    wa  = a & ~32'h3;
    idx = int'((wa >> 2) % SETS);
    @(posedge CLK); #1;
    nRST     = 1'b1;
    imemREN  = 1'b1;
    imemaddr = a;
    iwait    = 1'b1;
    @(negedge CLK);
    if (m_valid[idx] && m_addr[idx] == wa) begin
      total++;
      if (ihit !== 1'b1 || imemload !== m_data[idx] || iREN !== 1'b0) begin
        bad++;
        $display("FAIL hit @%h: ihit=%b load=%h iREN=%b, want 1 %h 0",
                 a, ihit, imemload, iREN, m_data[idx]);
      end
      exp_hits++;
      return;
    end
    total++;
    if (ihit !== 1'b0 || iREN !== 1'b0 || imemload !== 32'h0) begin
      bad++;
      $display("FAIL miss_detect @%h: ihit=%b iREN=%b load=%h, want 0 0 0",
               a, ihit, iREN, imemload);
    end
    exp_misses++;
    for (int k = 0; k <= waits; k++) begin
      @(posedge CLK); #1;
      iwait = (k < waits);
      if (perturb) begin
        imemREN  = 1'($urandom_range(1, 0));
        imemaddr = $urandom;
      end
      @(negedge CLK);
      total++;
      if (iREN !== 1'b1 || iaddr !== wa || ihit !== 1'b0) begin
        bad++;
        $display("FAIL fetch @%h cyc%0d: iREN=%b iaddr=%h ihit=%b, want 1 %h 0",
                 a, k, iREN, iaddr, ihit, wa);
      end
    end
    m_valid[idx] = 1'b1;
    m_addr[idx]  = wa;
    m_data[idx]  = mem_fn(wa);
    @(posedge CLK); #1;
    imemREN  = 1'b1;
    imemaddr = a;
    iwait    = 1'b1;
    @(negedge CLK);
    total++;
    if (ihit !== 1'b1 || imemload !== m_data[idx] || iREN !== 1'b0) begin
      bad++;
      $display("FAIL deliver @%h: ihit=%b load=%h iREN=%b, want 1 %h 0",
               a, ihit, imemload, iREN, m_data[idx]);
    end
    exp_hits++;
  endtask

  task automatic test_reset();
    nRST     = 1'b0;
    imemREN  = 1'b1;
    imemaddr = 32'h0;
    iwait    = 1'b1;
    model_clear();
    repeat (2) begin
      @(negedge CLK);
      total++;
      if (ihit !== 1'b0 || iREN !== 1'b0 || iaddr !== 32'h0
          || imemload !== 32'h0 || hit_count !== 32'h0
          || miss_count !== 32'h0) begin
        bad++;
        $display("FAIL reset: ihit=%b iREN=%b iaddr=%h load=%h hc=%0d mc=%0d, want all 0",
                 ihit, iREN, iaddr, imemload, hit_count, miss_count);
      end
    end
  endtask

  task automatic test_cold_miss();
    do_fetch(32'h0, 2, 1'b0);
    check_counters("cold_miss_counters");
  endtask

  task automatic test_repeat_hits();
    for (int i = 0; i < 5; i++)
      do_fetch(32'h0, 0, 1'b0);
    check_counters("repeat_counters");
  endtask

  task automatic test_conflict();
    do_fetch(32'h04, 1, 1'b0);
    do_fetch(32'h44, 0, 1'b0);
    do_fetch(32'h46, 0, 1'b0);
    do_fetch(32'h04, 0, 1'b0);
    check_counters("conflict_counters");
  endtask

  task automatic test_sweep();
    @(posedge CLK); #1;
    nRST    = 1'b0;
    imemREN = 1'b0;
    model_clear();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 16; i++)
        do_fetch(32'(i * 4), int'($urandom_range(3, 0)), 1'b0);
    check_counters("sweep_counters");
    total++;
    if (miss_count !== 32'd16) begin
      bad++;
      $display("FAIL sweep_misses: got %0d want 16", miss_count);
    end
  endtask

  task automatic test_reset_mid_fetch();
    @(posedge CLK); #1;
    imemREN  = 1'b1;
    imemaddr = 32'h100;
    iwait    = 1'b1;
    @(posedge CLK); #1;
    iwait = 1'b1;
    @(negedge CLK);
    total++;
    if (iREN !== 1'b1) begin
      bad++;
      $display("FAIL mid_fetch_iren: got %b want 1", iREN);
    end
    @(posedge CLK); #1;
    nRST = 1'b0;
    #1;
    total++;
    if (iREN !== 1'b0 || iaddr !== 32'h0 || ihit !== 1'b0
        || hit_count !== 32'h0 || miss_count !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_fetch: iREN=%b iaddr=%h ihit=%b hc=%0d mc=%0d, want 0",
               iREN, iaddr, ihit, hit_count, miss_count);
    end
    model_clear();
    imemREN = 1'b0;
    do_fetch(32'h100, 0, 1'b0);
    do_fetch(32'h000, 1, 1'b0);
    do_fetch(32'h03C, 0, 1'b0);
    check_counters("post_reset_counters");
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 300; i++) begin
      a = {$urandom_range(3, 0) == 0 ? 24'hABCDEF : 24'h0,
           8'($urandom_range(255, 0))};
      a[9:8] = 2'($urandom_range(3, 0));
      do_fetch(a, int'($urandom_range(3, 0)), 1'b1);
      if ($urandom_range(4, 0) == 0)
        check_counters("random_counters");
    end
    check_counters("random_final");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_cold_miss();
    test_repeat_hits();
    test_conflict();
    test_sweep();
    test_reset_mid_fetch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
